// File: rtl/wm_pkg.sv
// Shared constants for the washer front-panel conditioning stage:
// state encoding, program codes and default timing parameters.
package wm_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int ARM_TIMEOUT_DEF     = 64;
    localparam int NUM_PROGRAMS_DEF    = 4;

    localparam logic [2:0] COLD_WASH   = 3'd0;
    localparam logic [2:0] HOT_WASH    = 3'd1;
    localparam logic [2:0] RINSING_DRY = 3'd2;
    localparam logic [2:0] ONLY_DRY    = 3'd3;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_SELECT   = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_RUNNING  = 3'd3;
    localparam logic [2:0] ST_COMPLETE = 3'd4;

    typedef enum logic [2:0] {
        S_OFF      = ST_OFF,
        S_SELECT   = ST_SELECT,
        S_ARMED    = ST_ARMED,
        S_RUNNING  = ST_RUNNING,
        S_COMPLETE = ST_COMPLETE
    } state_t;

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// only flips after DEBOUNCE_CYCLES consecutive differing synced samples.
module wm_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_db;

endmodule

// File: rtl/wm_panel_ctrl.sv
// Washer front panel: debounced inputs, program latch, held start handshake
// with the sequencing FSM, door lock and completion indication.
module wm_panel_ctrl
    import wm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ARM_TIMEOUT     = ARM_TIMEOUT_DEF,
    parameter int NUM_PROGRAMS    = NUM_PROGRAMS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       btn_start_raw,
    input  logic       btn_prog_raw,
    input  logic       door_raw,
    input  logic       soap_raw,
    input  logic       busy,
    input  logic       done,
    output logic [2:0] program_selection,
    output logic       start,
    output logic       doorclosed,
    output logic       soap,
    output logic       door_lock,
    output logic       complete_led,
    output logic       start_error
);

    localparam int AW = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;

    logic w_start_db, w_prog_db, w_door_db, w_soap_db;

    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk(clk), .rst(rst), .i_raw(btn_start_raw), .o_level(w_start_db));
    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
        .clk(clk), .rst(rst), .i_raw(btn_prog_raw), .o_level(w_prog_db));
    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
        .clk(clk), .rst(rst), .i_raw(door_raw), .o_level(w_door_db));
    wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soap (
        .clk(clk), .rst(rst), .i_raw(soap_raw), .o_level(w_soap_db));

    logic r_start_prev, r_prog_prev, r_door_prev;
    logic w_start_p, w_prog_p, w_door_fall;

    assign w_start_p   = w_start_db & ~r_start_prev;
    assign w_prog_p    = w_prog_db & ~r_prog_prev;
    assign w_door_fall = r_door_prev & ~w_door_db;

    state_t        r_state, w_nxt_state;
    logic [2:0]    r_sel, w_nxt_sel;
    logic          r_start, w_nxt_start;
    logic          r_lock, w_nxt_lock;
    logic          r_led, w_nxt_led;
    logic          r_err, w_nxt_err;
    logic [AW-1:0] r_arm, w_nxt_arm;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_start = 1'b0;
        w_nxt_lock  = 1'b0;
        w_nxt_led   = 1'b0;
        w_nxt_err   = 1'b0;
        w_nxt_arm   = '0;
        if (!power) begin
            w_nxt_state = S_OFF;
            w_nxt_sel   = '0;
        end else begin
            case (r_state)
                S_OFF: w_nxt_state = S_SELECT;
                S_SELECT: begin
                    // start has priority over a simultaneous program step
                    if (w_start_p) begin
                        if (w_door_db) begin
                            w_nxt_state = S_ARMED;
                            w_nxt_start = 1'b1;
                            w_nxt_lock  = 1'b1;
                        end else begin
                            w_nxt_err = 1'b1;
                        end
                    end else if (w_prog_p) begin
                        w_nxt_sel = (r_sel == 3'(NUM_PROGRAMS - 1)) ? 3'd0 : r_sel + 3'd1;
                    end
                end
                S_ARMED: begin
                    if (busy) begin
                        w_nxt_state = S_RUNNING;
                        w_nxt_lock  = 1'b1;
                    end else if (!w_door_db || r_arm == AW'(ARM_TIMEOUT - 1)) begin
                        w_nxt_state = S_SELECT;
                        w_nxt_err   = 1'b1;
                    end else begin
                        w_nxt_start = 1'b1;
                        w_nxt_lock  = 1'b1;
                        w_nxt_arm   = r_arm + AW'(1);
                    end
                end
                S_RUNNING: begin
                    // busy dropping without done means the FSM was reset
                    if (done) begin
                        w_nxt_state = S_COMPLETE;
                        w_nxt_led   = 1'b1;
                    end else if (!busy) begin
                        w_nxt_state = S_SELECT;
                    end else begin
                        w_nxt_lock = 1'b1;
                    end
                end
                S_COMPLETE: begin
                    if (w_start_p || w_prog_p || w_door_fall)
                        w_nxt_state = S_SELECT;
                    else
                        w_nxt_led = 1'b1;
                end
                default: w_nxt_state = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_OFF;
            r_sel        <= '0;
            r_start      <= 1'b0;
            r_lock       <= 1'b0;
            r_led        <= 1'b0;
            r_err        <= 1'b0;
            r_arm        <= '0;
            r_start_prev <= 1'b0;
            r_prog_prev  <= 1'b0;
            r_door_prev  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_sel        <= w_nxt_sel;
            r_start      <= w_nxt_start;
            r_lock       <= w_nxt_lock;
            r_led        <= w_nxt_led;
            r_err        <= w_nxt_err;
            r_arm        <= w_nxt_arm;
            r_start_prev <= w_start_db;
            r_prog_prev  <= w_prog_db;
            r_door_prev  <= w_door_db;
        end
    end

    assign program_selection = r_sel;
    assign start             = r_start;
    assign door_lock         = r_lock;
    assign complete_led      = r_led;
    assign start_error       = r_err;
    assign doorclosed        = w_door_db;
    assign soap              = w_soap_db;

endmodule
